// File: rtl/vram_arbiter_if.sv
// Host request bus plus frame-buffer RAM port, as seen by the VRAM arbiter (slave)
// and by the host/RAM side (master).
interface vram_arbiter_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 24
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        output cpu_ack, cpu_rdata, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        input  cpu_ack, cpu_rdata, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/vram_arbiter.sv
// Frame-buffer RAM arbiter: raster prefetch FIFO for scanout vs. a req/ack host port.
// Optional saturating performance counters are built when VRAM_ARB_PERF_EN is defined.
module vram_arbiter #(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 24,
    parameter int FB_WORDS   = 76800,
    parameter int FIFO_DEPTH = 16,
    parameter int LOW_WM     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              pix_rd,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    output logic              underflow,
    vram_arbiter_if.slave     bus,
    output logic [15:0]       perf_cpu_stall,
    output logic [15:0]       perf_underflow
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        GNT_IDLE,
        GNT_DISP,
        GNT_CPU
    } grant_e;

    logic [ADDR_W-1:0] scan_addr_q;
    logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              disp_inflight_q;
    logic              cpu_inflight_q;
    logic              cpu_rd_q;
    logic              underflow_q;
    logic [DATA_W-1:0] head_q;
    logic [DATA_W-1:0] fifo_mem_q [FIFO_DEPTH];

    grant_e            gnt;
    logic [CNT_W-1:0]  level;
    logic              disp_elig, urgent, cpu_elig;
    logic              push, pop, uf_event;
    logic [CNT_W-1:0]  remaining;
    logic [PTR_W-1:0]  rd_next;
    logic [DATA_W-1:0] head_d;
    logic              head_load;

    assign level     = count_q + CNT_W'(disp_inflight_q);
    // A frame_start cycle owns the display state, so no fetch may start in it.
    assign disp_elig = !frame_start && (level < CNT_W'(FIFO_DEPTH));
    assign urgent    = level < CNT_W'(LOW_WM);
    assign cpu_elig  = bus.cpu_req && !cpu_inflight_q;

    always_comb begin
        gnt = GNT_IDLE;
        if (rst)                      gnt = GNT_IDLE;
        else if (disp_elig && urgent) gnt = GNT_DISP;
        else if (cpu_elig)            gnt = GNT_CPU;
        else if (disp_elig)           gnt = GNT_DISP;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (gnt)
            GNT_DISP: begin
                bus.mem_en   = 1'b1;
                bus.mem_addr = scan_addr_q;
            end
            GNT_CPU: begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = bus.cpu_we;
                bus.mem_addr  = bus.cpu_addr;
                bus.mem_wdata = bus.cpu_wdata;
            end
            default: ;
        endcase
    end

    // Returns of display reads issued before a frame_start are dropped.
    assign push     = disp_inflight_q && !frame_start;
    assign pop      = pix_rd && (count_q != '0);
    assign uf_event = pix_rd && (count_q == '0);

    // Head after this cycle: oldest surviving entry, else the word being pushed.
    assign remaining = count_q - CNT_W'(pop);
    assign rd_next   = rd_ptr_q + PTR_W'(pop);
    assign head_d    = (remaining != '0) ? fifo_mem_q[rd_next] : bus.mem_rdata;
    assign head_load = (remaining != '0) || push;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_addr_q     <= '0;
            rd_ptr_q        <= '0;
            wr_ptr_q        <= '0;
            count_q         <= '0;
            disp_inflight_q <= 1'b0;
            cpu_inflight_q  <= 1'b0;
            cpu_rd_q        <= 1'b0;
            underflow_q     <= 1'b0;
            head_q          <= '0;
        end else begin
            disp_inflight_q <= (gnt == GNT_DISP);
            cpu_inflight_q  <= (gnt == GNT_CPU);
            cpu_rd_q        <= (gnt == GNT_CPU) && !bus.cpu_we;
            if (frame_start) begin
                scan_addr_q <= '0;
                rd_ptr_q    <= '0;
                wr_ptr_q    <= '0;
                count_q     <= '0;
                underflow_q <= 1'b0;
            end else begin
                if (gnt == GNT_DISP)
                    scan_addr_q <= (scan_addr_q == ADDR_W'(FB_WORDS - 1)) ? '0
                                 : scan_addr_q + ADDR_W'(1);
                if (push)      wr_ptr_q    <= wr_ptr_q + PTR_W'(1);
                if (pop)       rd_ptr_q    <= rd_next;
                count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
                if (uf_event)  underflow_q <= 1'b1;
                if (head_load) head_q      <= head_d;
            end
        end
    end

    // NOTE: FIFO storage has no reset; count_q alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= bus.mem_rdata;
    end

    assign pix_data      = head_q;
    assign pix_valid     = (count_q != '0);
    assign underflow     = underflow_q;
    // Gated by rst so a transaction caught by reset never acknowledges.
    assign bus.cpu_ack   = cpu_inflight_q && !rst;
    assign bus.cpu_rdata = (cpu_rd_q && !rst) ? bus.mem_rdata : '0;

`ifdef VRAM_ARB_PERF_EN
    logic [15:0] stall_cnt_q, uf_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            uf_cnt_q    <= '0;
        end else begin
            if (bus.cpu_req && (gnt != GNT_CPU) && !cpu_inflight_q && (stall_cnt_q != 16'hFFFF))
                stall_cnt_q <= stall_cnt_q + 16'd1;
            if (uf_event && (uf_cnt_q != 16'hFFFF))
                uf_cnt_q <= uf_cnt_q + 16'd1;
        end
    end

    assign perf_cpu_stall = stall_cnt_q;
    assign perf_underflow = uf_cnt_q;
`else
    assign perf_cpu_stall = '0;
    assign perf_underflow = '0;
`endif
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: raster fill/scan order, host access, priority,
// underflow/frame_start handling, reset abort and (when built) perf counters.
module tb_vram_arbiter;
    localparam int FB = 76800;
`ifdef VRAM_ARB_PERF_EN
    localparam int POP_CYCLES = 40;
    localparam int EXP_STALL  = 3;
`else
    localparam int POP_CYCLES = 76810;
    localparam int EXP_STALL  = 0;
`endif

    logic        clk = 1'b0;
    logic        rst, frame_start, pix_rd;
    logic [23:0] pix_data;
    logic        pix_valid, underflow;
    logic [15:0] perf_cpu_stall, perf_underflow;
    logic [23:0] ram [FB];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          exp_pix, exp_fetch;

    vram_arbiter_if bus ();

    vram_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .frame_start    (frame_start),
        .pix_rd         (pix_rd),
        .pix_data       (pix_data),
        .pix_valid      (pix_valid),
        .underflow      (underflow),
        .bus            (bus),
        .perf_cpu_stall (perf_cpu_stall),
        .perf_underflow (perf_underflow)
    );

    always #5 clk = ~clk;

    // Synchronous-read single-port RAM, one cycle latency.
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            bus.mem_rdata <= ram[bus.mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        for (int a = 0; a < FB; a++) ram[a] = 24'(a);
        bus.mem_rdata = '0;
        rst = 1'b1; frame_start = 1'b0; pix_rd = 1'b0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;

        // Reset state
        cyc(); cyc(); #1;
        check("rst_mem_en", bus.mem_en, 0);
        check("rst_cpu_ack", bus.cpu_ack, 0);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_underflow", underflow, 0);
        check("rst_pix_data", pix_data, 0);
        check("rst_perf_stall", perf_cpu_stall, 0);
        check("rst_perf_uf", perf_underflow, 0);

        // Idle fill: fetches 0..15 then stops
        cyc(); rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            check("fill_en", bus.mem_en, 1);
            check("fill_addr", bus.mem_addr, i);
            cyc();
        end
        #1; check("fill_stop16", bus.mem_en, 0);
        cyc(); #1;
        check("fill_stop17", bus.mem_en, 0);
        check("fill_valid", pix_valid, 1);
        check("fill_head", pix_data, 0);

        // Continuous pop: scan order and fetch address wrap
        exp_pix = 0; exp_fetch = 16;
        for (int k = 0; k < POP_CYCLES; k++) begin
            pix_rd = 1'b1; #1;
            check("scan_pix", pix_data, exp_pix);
            if (bus.mem_en) begin
                check("scan_fetch", bus.mem_addr, exp_fetch);
                exp_fetch = (exp_fetch + 1) % FB;
            end
            cyc();
            exp_pix = (exp_pix + 1) % FB;
        end
        pix_rd = 1'b0; #1;
        check("scan_no_uf", underflow, 0);
        repeat (20) cyc();

        // Host write then read of addr 5 with the FIFO full
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 17'd5; bus.cpu_wdata = 24'h123456; #1;
        check("wr_en", bus.mem_en, 1);
        check("wr_we", bus.mem_we, 1);
        check("wr_addr", bus.mem_addr, 5);
        check("wr_data", bus.mem_wdata, 32'h123456);
        check("wr_no_ack_n", bus.cpu_ack, 0);
        cyc(); bus.cpu_req = 1'b0; #1;
        check("wr_ack", bus.cpu_ack, 1);
        check("wr_ack_idle", bus.mem_en, 0);
        cyc(); #1;
        check("wr_ack_pulse", bus.cpu_ack, 0);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; #1;
        check("rd_en", bus.mem_en, 1);
        check("rd_we", bus.mem_we, 0);
        check("rd_addr", bus.mem_addr, 5);
        cyc(); bus.cpu_req = 1'b0; #1;
        check("rd_ack", bus.cpu_ack, 1);
        check("rd_data", bus.cpu_rdata, 32'h123456);
        check("rd_head_kept", pix_data, exp_pix);
        cyc();

        // frame_start, then urgent display beats a held cpu_req until level reaches 4
        frame_start = 1'b1; #1;
        check("fs_no_fetch", bus.mem_en, 0);
        cyc(); frame_start = 1'b0; bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 17'd5; #1;
        check("fs_empty", pix_valid, 0);
        check("fs_head_hold", pix_data, exp_pix);
        check("urg_addr0", bus.mem_addr, 0);
        check("urg_we0", bus.mem_we, 0);
        for (int j = 1; j < 4; j++) begin
            cyc(); #1;
            check("urg_en", bus.mem_en, 1);
            check("urg_addr", bus.mem_addr, j);
        end
        check("urg_valid", pix_valid, 1);
        check("urg_head", pix_data, 0);
        cyc(); #1;
        check("cpu_after_wm", bus.mem_addr, 5);
        check("cpu_after_wm_en", bus.mem_en, 1);
        cyc(); bus.cpu_req = 1'b0; #1;
        check("cpu_wm_ack", bus.cpu_ack, 1);
        check("cpu_wm_rdata", bus.cpu_rdata, 32'h123456);
        check("disp_after_cpu", bus.mem_addr, 4);

        // Underflow on empty pop, then frame_start clears it and drops the in-flight read
        repeat (20) cyc();
        pix_rd = 1'b1; repeat (3) cyc(); pix_rd = 1'b0;
        repeat (20) cyc(); #1;
        check("uf_pre_head", pix_data, 3);
        frame_start = 1'b1;
        cyc(); frame_start = 1'b0; pix_rd = 1'b1; #1;
        check("uf_empty", pix_valid, 0);
        check("uf_fetch0", bus.mem_addr, 0);
        cyc(); pix_rd = 1'b0; frame_start = 1'b1; #1;
        check("uf_set", underflow, 1);
        check("uf_head_hold", pix_data, 3);
        check("uf_fs_no_fetch", bus.mem_en, 0);
        cyc(); frame_start = 1'b0; #1;
        check("uf_cleared", underflow, 0);
        check("drop_inflight", pix_valid, 0);
        check("refetch_en", bus.mem_en, 1);
        check("refetch_addr0", bus.mem_addr, 0);
        cyc(); #1;
        check("refetch_addr1", bus.mem_addr, 1);
        check("drop_still_empty", pix_valid, 0);
        cyc(); #1;
        check("refill_valid", pix_valid, 1);
        check("refill_head", pix_data, 0);

        // Reset during an in-flight host read: no acknowledge
        repeat (20) cyc();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 17'd5; #1;
        check("abort_grant", bus.mem_addr, 5);
        cyc(); rst = 1'b1; bus.cpu_req = 1'b0; #1;
        check("abort_no_ack", bus.cpu_ack, 0);
        check("abort_no_en", bus.mem_en, 0);
        cyc(); #1;
        check("abort_no_ack2", bus.cpu_ack, 0);
        check("abort_empty", pix_valid, 0);

        // Host stalled 3 cycles behind urgent display
        cyc(); rst = 1'b0; bus.cpu_req = 1'b1; #1;
        check("stall_c0", bus.mem_addr, 0);
        cyc(); #1; check("stall_c1", bus.mem_addr, 1);
        cyc(); #1; check("stall_c2", bus.mem_addr, 2);
        cyc(); bus.cpu_req = 1'b0; frame_start = 1'b1; #1;
        check("perf_stall", perf_cpu_stall, EXP_STALL);

        // Underflow counter: frame_start held keeps the FIFO empty
        cyc(); pix_rd = 1'b1;
        repeat (100) cyc(); #1;
`ifdef VRAM_ARB_PERF_EN
        check("perf_uf_100", perf_underflow, 100);
        repeat (69900) cyc(); #1;
        check("perf_uf_sat", perf_underflow, 16'hFFFF);
        check("perf_stall_kept", perf_cpu_stall, 3);
`else
        check("perf_uf_tied", perf_underflow, 0);
`endif
        pix_rd = 1'b0; frame_start = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
